// File: rtl/aes_block_sequencer_pkg.sv
// aes_seq_pkg: shared block width, sequencer state encoding and word-count helper.
//   BLOCK_W : AES block width (128)
//   state_e : S_FILL / S_LOAD / S_WAIT / S_DRAIN
//   words() : number of stream words per block for a given word width
package aes_seq_pkg;
    localparam int BLOCK_W = 128;
    typedef enum logic [1:0] {S_FILL, S_LOAD, S_WAIT, S_DRAIN} state_e;
    function automatic int words(input int word_w);
        return BLOCK_W / word_w;
    endfunction
endpackage

// File: rtl/aes_block_sequencer_if.sv
// aes_block_sequencer_if: plaintext-in / ciphertext-out word streams.
//   s_valid/s_ready/s_data : plaintext words toward the sequencer
//   m_valid/m_ready/m_data : ciphertext words from the sequencer
//   master = host/DMA side, slave = sequencer side
interface aes_block_sequencer_if #(parameter int WORD_W = 32);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/aes_block_sequencer_shift.sv
// aes_blk_shift: 128-bit register with parallel load and WORD_W-wide left shift.
//   clk, rst          : clock, asynchronous active-low reset
//   load_i/load_val_i : parallel load (wins over shift)
//   shift_i/shift_in_i: shift left by WORD_W, new word enters at the LS end
//   q_o               : top OUT_W bits of the register
module aes_blk_shift
    import aes_seq_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int OUT_W  = BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] load_val_i,
    input  logic               shift_i,
    input  logic [WORD_W-1:0]  shift_in_i,
    output logic [OUT_W-1:0]   q_o
);
    logic [BLOCK_W-1:0] q_q, q_d;

    // Shift written as a full-width shift so WORD_W == BLOCK_W degenerates cleanly.
    always_comb q_d = load_i ? load_val_i :
                      shift_i ? ((q_q << WORD_W) | BLOCK_W'(shift_in_i)) : q_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) q_q <= '0;
        else      q_q <= q_d;

    assign q_o = q_q[BLOCK_W-1 -: OUT_W];
endmodule

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: packs a word stream into 128-bit blocks for an AES core and streams the result back.
//   clk, rst              : clock, asynchronous active-low reset
//   key_in, key_we        : key register load (only while idle: S_FILL with no word held)
//   iv_in, iv_we          : chain register load, present only with AES_CBC_CHAIN_EN defined
//   bus (slave)           : s_* plaintext words in (MS word first), m_* ciphertext words out (MS word first)
//   aes_ld                : one-cycle load pulse to the cipher
//   aes_key, aes_text_in  : key and block (block ^ chain with AES_CBC_CHAIN_EN) to the cipher
//   aes_text_out, aes_done: cipher result
//   busy                  : block in flight or partially filled
//   err_timeout           : sticky watchdog flag, cleared only by reset
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic               key_we,
`ifdef AES_CBC_CHAIN_EN
    input  logic [BLOCK_W-1:0] iv_in,
    input  logic               iv_we,
`endif
    aes_block_sequencer_if.slave bus,
    output logic               aes_ld,
    output logic [BLOCK_W-1:0] aes_key,
    output logic [BLOCK_W-1:0] aes_text_in,
    input  logic [BLOCK_W-1:0] aes_text_out,
    input  logic               aes_done,
    output logic               busy,
    output logic               err_timeout
);
    localparam int WORDS = words(WORD_W);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [TW-1:0]      wd_q;
    logic [BLOCK_W-1:0] key_q, fill_q;
    logic [WORD_W-1:0]  m_data;
    logic               s_ready_q, err_q;

    logic fill_beat, drain_beat, capture, idle, last;
    assign fill_beat  = bus.s_valid & s_ready_q;
    assign drain_beat = (state_q == S_DRAIN) & bus.m_ready;
    // aes_done only counts from the cycle after aes_ld, i.e. in S_WAIT.
    assign capture    = (state_q == S_WAIT) & aes_done;
    assign idle       = (state_q == S_FILL) & (cnt_q == '0);
    assign last       = cnt_q == CW'(WORDS - 1);

    // s_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= S_FILL;
            cnt_q     <= '0;
            wd_q      <= '0;
            key_q     <= '0;
            s_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (key_we && idle) key_q <= key_in;
            case (state_q)
                S_FILL: begin
                    s_ready_q <= !(fill_beat && last);
                    if (fill_beat) begin
                        cnt_q   <= last ? '0 : cnt_q + 1'b1;
                        state_q <= last ? S_LOAD : S_FILL;
                    end
                end
                S_LOAD: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT:
                    if (aes_done) state_q <= S_DRAIN;
                    else if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_q     <= 1'b1;
                        state_q   <= S_FILL;
                        s_ready_q <= 1'b1;
                    end else wd_q <= wd_q + 1'b1;
                S_DRAIN:
                    if (drain_beat) begin
                        cnt_q     <= last ? '0 : cnt_q + 1'b1;
                        state_q   <= last ? S_FILL : S_DRAIN;
                        s_ready_q <= last;
                    end
            endcase
        end

    aes_blk_shift #(.WORD_W(WORD_W), .OUT_W(BLOCK_W)) u_fill (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (fill_beat),
        .shift_in_i (bus.s_data),
        .q_o        (fill_q)
    );

    aes_blk_shift #(.WORD_W(WORD_W), .OUT_W(WORD_W)) u_drain (
        .clk        (clk),
        .rst        (rst),
        .load_i     (capture),
        .load_val_i (aes_text_out),
        .shift_i    (drain_beat),
        .shift_in_i ('0),
        .q_o        (m_data)
    );

`ifdef AES_CBC_CHAIN_EN
    logic [BLOCK_W-1:0] chain_q;
    // A timeout never reaches capture, so the chain survives an abandoned block.
    always_ff @(posedge clk or negedge rst)
        if (!rst)                chain_q <= '0;
        else if (capture)        chain_q <= aes_text_out;
        else if (iv_we && idle)  chain_q <= iv_in;
    assign aes_text_in = fill_q ^ chain_q;
`else
    assign aes_text_in = fill_q;
`endif

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = state_q == S_DRAIN;
    assign bus.m_data  = m_data;
    assign aes_ld      = state_q == S_LOAD;
    assign aes_key     = key_q;
    assign busy        = (state_q != S_FILL) | (cnt_q != '0);
    assign err_timeout = err_q;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb_aes_block_sequencer: scoreboard bench with a behavioural AES-128 cipher on the aes_* ports.
module tb_aes_block_sequencer;
    import aes_seq_pkg::*;
    localparam int WORD_W = 32, TIMEOUT_CYC = 64, LAT = 10;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic clk = 0, rst = 1;
    logic [127:0] key_in = '0;
    logic key_we = 0;
`ifdef AES_CBC_CHAIN_EN
    logic [127:0] iv_in = '0;
    logic iv_we = 0;
    logic [127:0] tb_chain = '0;
`endif
    logic aes_ld, aes_done = 0, busy, err_timeout;
    logic [127:0] aes_key, aes_text_in, aes_text_out = '0;

    aes_block_sequencer_if #(.WORD_W(WORD_W)) bus();

    aes_block_sequencer #(.WORD_W(WORD_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_we(key_we),
`ifdef AES_CBC_CHAIN_EN
        .iv_in(iv_in), .iv_we(iv_we),
`endif
        .bus(bus), .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_text_out(aes_text_out), .aes_done(aes_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [31:0] exp_q [$];
    logic [127:0] cur_key = '0;
    bit cipher_en = 1, glitch = 0, rand_rdy = 0;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc = 8'h01;
        logic [31:0] tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
            for (int c = 0; c < 4; c++)
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end else
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] exp_block(input logic [127:0] pt);
`ifdef AES_CBC_CHAIN_EN
        tb_chain = aes_ref(cur_key, pt ^ tb_chain);
        return tb_chain;
`else
        return aes_ref(cur_key, pt);
`endif
    endfunction

    // ---------------- cipher model ----------------
    int lat_cnt = -1;
    logic [127:0] res;
    always @(negedge clk) begin
        aes_done = 0;
        if (!rst) lat_cnt = -1;
        else if (aes_ld) begin
            res = aes_ref(aes_key, aes_text_in);
            lat_cnt = cipher_en ? LAT : -1;
            if (glitch) begin
                aes_done = 1;
                aes_text_out = ~res;
            end
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                aes_done = 1;
                aes_text_out = res;
                lat_cnt = -1;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    logic pv = 0, pr = 0;
    logic [31:0] pd, e;
    always @(negedge clk) begin
        if (!rst) pv = 0;
        else begin
            if (pv && !pr) begin
                tests++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== pd) begin
                    fails++;
                    $display("FAIL hold: m_valid=%b m_data=%h, want 1 %h", bus.m_valid, bus.m_data, pd);
                end
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_word: got %h, want no word", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e) begin
                        fails++;
                        $display("FAIL m_data: got %h, want %h", bus.m_data, e);
                    end
                end
            end
            pv = bus.m_valid;
            pr = bus.m_ready;
            pd = bus.m_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_key(input logic [127:0] k);
        @(posedge clk); #1;
        key_in = k; key_we = 1; cur_key = k;
`ifdef AES_CBC_CHAIN_EN
        iv_in = '0; iv_we = 1; tb_chain = '0;
`endif
        @(posedge clk); #1;
        key_we = 0;
`ifdef AES_CBC_CHAIN_EN
        iv_we = 0;
`endif
    endtask

    task automatic push_exp(input logic [127:0] c);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[127-32*i -: 32]);
    endtask

    task automatic send_words(input logic [127:0] pt, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            int n = 0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.s_valid = 1;
            bus.s_data = pt[127-32*i -: 32];
            do begin @(negedge clk); n++; end while (bus.s_ready !== 1'b1 && n < 500);
            if (bus.s_ready !== 1'b1) begin
                tests++; fails++;
                $display("FAIL s_ready_wait: got %b, want 1 within 500 cycles", bus.s_ready);
            end
            @(posedge clk); #1;
            bus.s_valid = 0;
            key_we = 0;
        end
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin @(negedge clk); n++; end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL drain_wait: got %0d words pending busy=%b, want 0 pending busy=0", exp_q.size(), busy);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #2 rst = 0;
        #2;
        tests++;
        if ({bus.s_ready, bus.m_valid, aes_ld, busy, err_timeout} !== 5'b0 || aes_key !== '0 ||
            aes_text_in !== '0 || bus.m_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b key=%h txt=%h md=%h, want all 0",
                     {bus.s_ready, bus.m_valid, aes_ld, busy, err_timeout}, aes_key, aes_text_in, bus.m_data);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        tests++;
        if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL s_ready_release: got %b, want 0", bus.s_ready); end
        @(posedge clk); #1;
        tests++;
        if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL s_ready_rise: got %b, want 1", bus.s_ready); end
    endtask

    task automatic test_known_vector;
        load_key(K1);
        push_exp(C1);
        send_words(P1, 0, 3, 0);
        wait_idle();
    endtask

    task automatic test_key;
        load_key(K1);
        push_exp(C1);
        glitch = 1;
        send_words(P1, 0, 1, 0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_partial: got %b, want 1", busy); end
        key_in = K2; key_we = 1;
        @(posedge clk); #1 key_we = 0;
        send_words(P1, 2, 3, 0);
        tests++;
        if (aes_ld !== 1'b1 || aes_key !== K1) begin
            fails++;
            $display("FAIL key_midfill: got ld=%b key=%h, want 1 %h", aes_ld, aes_key, K1);
        end
        wait_idle();
        glitch = 0;
        key_in = K2; key_we = 1; cur_key = K2;
        push_exp(exp_block(P2));
        send_words(P2, 0, 3, 0);
        wait_idle();
    endtask

    task automatic test_gaps;
        load_key(K2);
        rand_rdy = 1;
        push_exp(C2);
        void'(exp_block(P2));
        push_exp(exp_block(P2B));
        send_words(P2, 0, 3, 1);
        send_words(P2B, 0, 3, 1);
        wait_idle();
        rand_rdy = 0;
    endtask

    task automatic test_back_to_back;
        logic [127:0] pts [3];
        load_key({$urandom, $urandom, $urandom, $urandom});
        rand_rdy = 1;
        for (int b = 0; b < 3; b++) begin
            pts[b] = {$urandom, $urandom, $urandom, $urandom};
            push_exp(exp_block(pts[b]));
        end
        for (int b = 0; b < 3; b++) send_words(pts[b], 0, 3, b == 1);
        wait_idle();
        rand_rdy = 0;
    endtask

    task automatic test_timeout;
        int n = 0;
        bit saw_mv = 0;
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        cipher_en = 0;
        send_words(pt, 0, 3, 0);
        @(posedge clk);
        do begin
            @(posedge clk); #1;
            n++;
            saw_mv |= bus.m_valid;
        end while (err_timeout !== 1'b1 && n < 200);
        tests++;
        if (n != TIMEOUT_CYC) begin fails++; $display("FAIL timeout_cycles: got %0d, want %0d", n, TIMEOUT_CYC); end
        tests++;
        if (saw_mv) begin fails++; $display("FAIL timeout_m_valid: got 1, want 0"); end
        tests++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_resume: got s_ready=%b busy=%b, want 1 0", bus.s_ready, busy);
        end
        cipher_en = 1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        push_exp(exp_block(pt));
        send_words(pt, 0, 3, 0);
        wait_idle();
        tests++;
        if (err_timeout !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b, want 1", err_timeout); end
    endtask

    task automatic test_reset_in_wait;
        send_words({$urandom, $urandom, $urandom, $urandom}, 0, 3, 0);
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1;
        exp_q.delete();
`ifdef AES_CBC_CHAIN_EN
        tb_chain = '0;
`endif
        tests++;
        if ({bus.s_ready, bus.m_valid, aes_ld, busy, err_timeout} !== 5'b0 || aes_key !== '0 ||
            aes_text_in !== '0 || bus.m_data !== '0) begin
            fails++;
            $display("FAIL reset_wait: got %b key=%h txt=%h md=%h, want all 0",
                     {bus.s_ready, bus.m_valid, aes_ld, busy, err_timeout}, aes_key, aes_text_in, bus.m_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1;
        load_key(K1);
        push_exp(C1);
        send_words(P1, 0, 3, 0);
        wait_idle();
    endtask

`ifdef AES_CBC_CHAIN_EN
    task automatic test_cbc;
        @(posedge clk); #1;
        key_in = K2; key_we = 1; cur_key = K2;
        iv_in = K1; iv_we = 1;
        @(posedge clk); #1;
        key_we = 0; iv_we = 0;
        tb_chain = 128'h5086cb9b507219ee95db113a917678b2;
        push_exp(128'h7649abac8119b246cee98e9b12e9197d);
        push_exp(128'h5086cb9b507219ee95db113a917678b2);
        send_words(P2, 0, 3, 0);
        send_words(P2B, 0, 3, 0);
        wait_idle();
    endtask
`endif

    initial begin
        bus.s_valid = 0;
        bus.s_data = '0;
        bus.m_ready = 1;
        test_reset();
        test_known_vector();
        test_key();
        test_gaps();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
`ifdef AES_CBC_CHAIN_EN
        test_cbc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish before 500000");
        $fatal(1, "bench timeout");
    end
endmodule
